dmem_router: RTL and testbench
==============================

Name: dmem_router

Overview:
- Parametrised data-side memory-map router between the 3-stage core's memory port and N address regions (dmem, imem, bios, io, and future regions).
- Successor to the fixed 4-bit upper-nibble decoder:
  - region count and tags are parameters;
  - per-region write protection;
  - a registered read-return path matched to one-cycle synchronous BRAMs;
  - one slow region served through a req/ack handshake, with core stall and timeout;
  - access-fault reporting.

Parameters:
- XLEN, 32, data/address width.
- NUM_REGIONS, 4, number of decoded regions (1..8).
- TAG_BITS, 4, number of upper address bits compared (addr[XLEN-1 -: TAG_BITS]).
- REGION_TAGS, {4'h8,4'h4,4'h2,4'h1}, packed NUM_REGIONS*TAG_BITS; the slice for region i sits at bits [i*TAG_BITS +: TAG_BITS].
- WR_MASK, 4'b1011, bit i=1 means region i is writable.
- SLOW_REGION, 3, index of the handshaked region; NUM_REGIONS means none.
- TIMEOUT_CYCLES, 255, maximum wait for slow_ack (1..255).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req_valid  in  1  core issues a load or store this cycle.
- cpu_addr  in  XLEN  byte address.
- cpu_wdata  in  XLEN  store data, already lane-aligned.
- cpu_wea  in  4  byte write enables; 0 means load.
- cpu_stall  out  1  core must hold its request and pipeline.
- cpu_rdata  out  XLEN  load data.
- cpu_rdata_valid  out  1  cpu_rdata is valid this cycle.
- fault  out  1  one-cycle pulse on an illegal access.
- fault_addr  out  XLEN  address of the most recent fault.
- fault_count  out  8  saturating fault counter.
- rgn_addr  out  XLEN  address to all regions.
- rgn_wdata  out  XLEN  write data to all regions.
- rgn_wea  out  NUM_REGIONS*4  per-region byte enables.
- rgn_rdata  in  NUM_REGIONS*XLEN  per-region synchronous read data.
- slow_req  out  1  slow-region request, level held until ack.
- slow_ack  in  1  slow region completes; its rdata slice is valid in the same cycle.

Behaviour:
- Reset (asynchronous): every output goes to 0, FSM to IDLE, internal registers cleared. Reset mid-handshake drops slow_req in the same instant; a late slow_ack is ignored.
- Decode (combinational, in IDLE with cpu_req_valid): hit_i = (addr tag == REGION_TAGS slice i). If several regions hit, the lowest index wins. No hit means unmapped.
- rgn_addr and rgn_wdata:
  - In IDLE they pass cpu_addr/cpu_wdata through.
  - In the slow states they present the latched copies.
- Fast store (hit region i is writable and not slow): rgn_wea slice i = cpu_wea in the same cycle; all other slices are 0. No stall, no rdata_valid.
- Fast load: register sel_q = i and rd_pend = 1. In cycle N+1: cpu_rdata = rgn_rdata slice sel_q and cpu_rdata_valid = 1. Latency is exactly 1. Back-to-back loads are supported every cycle.
- Fault conditions:
  - store to a read-only region;
  - any access to an unmapped address.
- Fault response:
  - all wea are suppressed;
  - fault pulses 1 cycle later, and fault_addr latches;
  - fault_count increments, saturating at 255;
  - an unmapped load also returns cpu_rdata = 0 with valid = 1 at N+1.
- Slow FSM, states IDLE / SLOW_WAIT / SLOW_RESP:
  - IDLE -> SLOW_WAIT on a valid hit to SLOW_REGION. In that cycle cpu_stall = 1 combinationally; addr, wdata and wea are latched; the timeout counter is cleared.
  - SLOW_WAIT:
    - slow_req = 1 and cpu_stall = 1;
    - rgn_wea SLOW slice = latched wea, qualified by WR_MASK;
    - the counter increments each cycle.
  - On slow_ack: capture the slow rdata slice into a register, then go to SLOW_RESP. cpu_stall = 1 in the ack cycle; slow_req drops next cycle.
  - If the counter reaches TIMEOUT_CYCLES with no ack: fault, captured data = 0, go to SLOW_RESP. Ack and timeout in the same cycle: ack wins, no fault.
  - SLOW_RESP (1 cycle): cpu_stall = 0. cpu_rdata_valid = 1 for loads; stores produce no valid. Then back to IDLE.
  - A slow store to a read-only slow region faults in IDLE; no handshake is started.
- cpu_req_valid is ignored while cpu_stall = 1; the core re-presents the same request.

Decomposition:
- Shared package/defines:
  - XLEN;
  - FSM state encodings (IDLE = 2'd0, SLOW_WAIT = 2'd1, SLOW_RESP = 2'd2);
  - default region tag constants (TAG_DMEM = 4'h1, TAG_IMEM = 4'h2, TAG_BIOS = 4'h4, TAG_IO = 4'h8).
- One natural sub-module: region_decoder. It is a parametrised priority tag match producing a one-hot hit vector, an encoded index and an unmapped flag. The FSM, return registers and fault logic stay in dmem_router.

Test Plan:
- Store 0xDEADBEEF, wea = 4'hF to 0x1000_0010 -> rgn_wea[3:0] = 4'hF that cycle, other slices 0, no stall, no fault.
- Loads on consecutive cycles to 0x1000_0000 then 0x4000_0004, with region 0 returning 0x11 and region 2 returning 0x22 -> rdata_valid in cycles N+1 and N+2 with 0x11 then 0x22.
- Store to 0x4000_0000 (read-only bios) -> all wea 0; fault pulses at N+1; fault_addr = 0x4000_0000; fault_count = 1.
- Load from 0x8000_0018 with slow_ack after 5 cycles and data 0xA5 -> stall for 6 cycles, slow_req for 5, rdata_valid with 0xA5 one cycle after ack.
- Slow load with no ack, TIMEOUT_CYCLES = 8 -> fault after 8 wait cycles, rdata = 0 with valid, stall released.
- Assert rst_n low mid SLOW_WAIT -> slow_req and cpu_stall drop to 0 immediately; FSM is in IDLE after release; a later slow_ack produces no rdata_valid.

Source files
------------

// File: rtl/dmem_router_pkg.sv
// Shared constants for the data-side memory-map router: default width,
// slow-path FSM encoding and the default region tags.
package dmem_router_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SLOW_WAIT = 2'd1,
    SLOW_RESP = 2'd2
  } state_e;

  localparam logic [3:0] TAG_DMEM = 4'h1;
  localparam logic [3:0] TAG_IMEM = 4'h2;
  localparam logic [3:0] TAG_BIOS = 4'h4;
  localparam logic [3:0] TAG_IO   = 4'h8;

endpackage

// File: rtl/dmem_router_region_decoder.sv
// Priority tag match: the lowest-indexed region whose tag equals the address
// tag wins; no match raises unmapped.
module dmem_router_region_decoder #(
  parameter int NUM_REGIONS = 4,
  parameter int TAG_BITS    = 4,
  parameter int IDX_W       = 2,
  parameter logic [NUM_REGIONS*TAG_BITS-1:0] REGION_TAGS = '0
) (
  input  logic [TAG_BITS-1:0]    tag,
  output logic [NUM_REGIONS-1:0] hit,
  output logic [IDX_W-1:0]       idx,
  output logic                   unmapped
);

  logic found;

  always_comb begin
    hit   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!found && (REGION_TAGS[i*TAG_BITS +: TAG_BITS] == tag)) begin
        found  = 1'b1;
        hit[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
    unmapped = !found;
  end

endmodule

// File: rtl/dmem_router.sv
// Data-side memory-map router: fast one-cycle BRAM regions, one handshaked
// slow region with stall and timeout, write protection and fault reporting.
module dmem_router #(
  parameter int XLEN           = dmem_router_pkg::XLEN,
  parameter int NUM_REGIONS    = 4,
  parameter int TAG_BITS       = 4,
  parameter logic [NUM_REGIONS*TAG_BITS-1:0] REGION_TAGS = {
    dmem_router_pkg::TAG_IO, dmem_router_pkg::TAG_BIOS,
    dmem_router_pkg::TAG_IMEM, dmem_router_pkg::TAG_DMEM},
  parameter logic [NUM_REGIONS-1:0] WR_MASK = 4'b1011,
  parameter int SLOW_REGION    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_req_valid,
  input  logic [XLEN-1:0]             cpu_addr,
  input  logic [XLEN-1:0]             cpu_wdata,
  input  logic [3:0]                  cpu_wea,
  output logic                        cpu_stall,
  output logic [XLEN-1:0]             cpu_rdata,
  output logic                        cpu_rdata_valid,
  output logic                        fault,
  output logic [XLEN-1:0]             fault_addr,
  output logic [7:0]                  fault_count,
  output logic [XLEN-1:0]             rgn_addr,
  output logic [XLEN-1:0]             rgn_wdata,
  output logic [NUM_REGIONS*4-1:0]    rgn_wea,
  input  logic [NUM_REGIONS*XLEN-1:0] rgn_rdata,
  output logic                        slow_req,
  input  logic                        slow_ack
);
  import dmem_router_pkg::*;

  localparam int         IDX_W    = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam bit         HAS_SLOW = (SLOW_REGION < NUM_REGIONS);
  localparam int         SLOW_IDX = HAS_SLOW ? SLOW_REGION : 0;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                  state;
  logic [XLEN-1:0]         addr_q;
  logic [XLEN-1:0]         wdata_q;
  logic [3:0]              wea_q;
  logic [7:0]              cnt;
  logic [XLEN-1:0]         slow_data_q;
  logic [IDX_W-1:0]        sel_q;
  logic                    rd_pend;
  logic                    rd_zero;

  logic [NUM_REGIONS-1:0]  hit;
  logic [IDX_W-1:0]        idx;
  logic                    unmapped;

  dmem_router_region_decoder #(
    .NUM_REGIONS (NUM_REGIONS),
    .TAG_BITS    (TAG_BITS),
    .IDX_W       (IDX_W),
    .REGION_TAGS (REGION_TAGS)
  ) u_decoder (
    .tag      (cpu_addr[XLEN-1 -: TAG_BITS]),
    .hit      (hit),
    .idx      (idx),
    .unmapped (unmapped)
  );

  logic in_idle, acc, is_store, hit_slow, ro_store;
  logic idle_fault, start_slow, fast_store, fast_load, unm_load;
  logic slow_tmo, fault_now, resp_load;
  logic [XLEN-1:0] slow_rdata;

  assign in_idle    = (state == IDLE);
  assign acc        = in_idle && cpu_req_valid;
  assign is_store   = |cpu_wea;
  assign hit_slow   = HAS_SLOW && hit[SLOW_IDX];
  assign ro_store   = is_store && |(hit & ~WR_MASK);
  assign idle_fault = acc && (unmapped || ro_store);
  // A store to a read-only slow region faults here and never starts the handshake.
  assign start_slow = acc && hit_slow && !ro_store;
  assign fast_store = acc && !unmapped && !hit_slow && is_store && !ro_store;
  assign fast_load  = acc && !unmapped && !hit_slow && !is_store;
  assign unm_load   = acc && unmapped && !is_store;
  // Ack in the last wait cycle takes precedence over the timeout.
  assign slow_tmo   = (state == SLOW_WAIT) && !slow_ack && (cnt == TMO_LAST);
  assign fault_now  = idle_fault || slow_tmo;
  assign resp_load  = (wea_q == 4'h0);
  assign slow_rdata = rgn_rdata[SLOW_IDX*XLEN +: XLEN];

  assign cpu_stall  = start_slow || (state == SLOW_WAIT);
  assign slow_req   = (state == SLOW_WAIT);
  assign rgn_addr   = in_idle ? cpu_addr  : addr_q;
  assign rgn_wdata  = in_idle ? cpu_wdata : wdata_q;

  always_comb begin
    rgn_wea = '0;
    if (fast_store)
      rgn_wea[int'(idx)*4 +: 4] = cpu_wea;
    if (HAS_SLOW && (state == SLOW_WAIT))
      rgn_wea[SLOW_IDX*4 +: 4] = wea_q & {4{WR_MASK[SLOW_IDX]}};
  end

  always_comb begin
    cpu_rdata       = '0;
    cpu_rdata_valid = 1'b0;
    if (rd_pend) begin
      cpu_rdata_valid = 1'b1;
      if (!rd_zero)
        cpu_rdata = rgn_rdata[int'(sel_q)*XLEN +: XLEN];
    end
    if ((state == SLOW_RESP) && resp_load) begin
      cpu_rdata_valid = 1'b1;
      cpu_rdata       = slow_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wea_q       <= '0;
      cnt         <= '0;
      slow_data_q <= '0;
      sel_q       <= '0;
      rd_pend     <= 1'b0;
      rd_zero     <= 1'b0;
      fault       <= 1'b0;
      fault_addr  <= '0;
      fault_count <= '0;
    end else begin
      rd_pend <= fast_load || unm_load;
      rd_zero <= unm_load;
      if (fast_load)
        sel_q <= idx;
      fault <= fault_now;
      if (fault_now) begin
        fault_addr <= slow_tmo ? addr_q : cpu_addr;
        if (fault_count != 8'hFF)
          fault_count <= fault_count + 8'd1;
      end
      case (state)
        IDLE: begin
          if (start_slow) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            wea_q   <= cpu_wea;
            cnt     <= '0;
            state   <= SLOW_WAIT;
          end
        end
        SLOW_WAIT: begin
          if (slow_ack) begin
            slow_data_q <= slow_rdata;
            state       <= SLOW_RESP;
          end else if (cnt == TMO_LAST) begin
            slow_data_q <= '0;
            state       <= SLOW_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SLOW_RESP: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_router.sv
// Directed bench for dmem_router: fast stores/loads, write protection,
// slow-region handshake, timeout, unmapped access and reset mid-handshake.
module tb_dmem_router;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req_valid;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_wea;
  logic         cpu_stall;
  logic [31:0]  cpu_rdata;
  logic         cpu_rdata_valid;
  logic         fault;
  logic [31:0]  fault_addr;
  logic [7:0]   fault_count;
  logic [31:0]  rgn_addr;
  logic [31:0]  rgn_wdata;
  logic [15:0]  rgn_wea;
  logic [127:0] rgn_rdata;
  logic         slow_req;
  logic         slow_ack;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_router #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_wea         (cpu_wea),
    .cpu_stall       (cpu_stall),
    .cpu_rdata       (cpu_rdata),
    .cpu_rdata_valid (cpu_rdata_valid),
    .fault           (fault),
    .fault_addr      (fault_addr),
    .fault_count     (fault_count),
    .rgn_addr        (rgn_addr),
    .rgn_wdata       (rgn_wdata),
    .rgn_wea         (rgn_wea),
    .rgn_rdata       (rgn_rdata),
    .slow_req        (slow_req),
    .slow_ack        (slow_ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w);
    cpu_req_valid = v;
    cpu_addr      = a;
    cpu_wdata     = d;
    cpu_wea       = w;
  endtask

  task automatic idle_bus();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic set_rd(input int r, input logic [31:0] v);
    rgn_rdata[r*32 +: 32] = v;
  endtask

  task automatic check_rd(input string tag);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    check({tag, "_valid"}, cpu_rdata_valid, 1);
    check({tag, "_data"}, cpu_rdata, e);
  endtask

  initial begin
    int stall_cnt;
    int req_cnt;
    int wait_cnt;

    rst_n     = 1'b0;
    slow_ack  = 1'b0;
    rgn_rdata = '0;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    settle();
    check("rst_stall", cpu_stall, 0);
    check("rst_valid", cpu_rdata_valid, 0);
    check("rst_fault", fault, 0);
    check("rst_fcount", fault_count, 0);
    check("rst_faddr", fault_addr, 0);
    check("rst_req", slow_req, 0);
    check("rst_wea", rgn_wea, 0);
    rst_n = 1'b1;

    // fast store to dmem
    tick(); drive(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF); settle();
    check("st_wea", rgn_wea, 16'h000F);
    check("st_stall", cpu_stall, 0);
    check("st_addr", rgn_addr, 32'h1000_0010);
    check("st_wdata", rgn_wdata, 32'hDEAD_BEEF);
    tick(); idle_bus(); settle();
    check("st_fault", fault, 0);
    check("st_valid", cpu_rdata_valid, 0);

    // back-to-back fast loads
    set_rd(0, 32'h11);
    set_rd(2, 32'h22);
    tick(); drive(1'b1, 32'h1000_0000, 32'h0, 4'h0); exp_q.push_back(32'h11); settle();
    check("ld0_wea", rgn_wea, 0);
    check("ld0_stall", cpu_stall, 0);
    tick(); drive(1'b1, 32'h4000_0004, 32'h0, 4'h0); exp_q.push_back(32'h22); settle();
    check_rd("ld0");
    tick(); idle_bus(); settle();
    check_rd("ld1");
    tick(); settle();
    check("ld_end_valid", cpu_rdata_valid, 0);

    // store to read-only bios
    tick(); drive(1'b1, 32'h4000_0000, 32'h1234_5678, 4'hF); settle();
    check("ro_wea", rgn_wea, 0);
    check("ro_stall", cpu_stall, 0);
    tick(); idle_bus(); settle();
    check("ro_fault", fault, 1);
    check("ro_faddr", fault_addr, 32'h4000_0000);
    check("ro_fcount", fault_count, 1);
    check("ro_valid", cpu_rdata_valid, 0);
    tick(); settle();
    check("ro_fault_pulse", fault, 0);

    // slow load, ack in the fifth wait cycle
    stall_cnt = 0;
    req_cnt   = 0;
    tick(); drive(1'b1, 32'h8000_0018, 32'h0, 4'h0); settle();
    stall_cnt += int'(cpu_stall);
    req_cnt   += int'(slow_req);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 5) begin
        slow_ack = 1'b1;
        set_rd(3, 32'hA5);
      end
      settle();
      stall_cnt += int'(cpu_stall);
      req_cnt   += int'(slow_req);
    end
    check("sl_addr", rgn_addr, 32'h8000_0018);
    tick(); slow_ack = 1'b0; idle_bus(); exp_q.push_back(32'hA5); settle();
    check_rd("sl_rd");
    check("sl_stall_rel", cpu_stall, 0);
    check("sl_req_rel", slow_req, 0);
    check("sl_stall_cycles", stall_cnt, 6);
    check("sl_req_cycles", req_cnt, 5);
    tick(); settle();
    check("sl_end_valid", cpu_rdata_valid, 0);

    // slow load timeout
    tick(); drive(1'b1, 32'h8000_0020, 32'h0, 4'h0); settle();
    wait_cnt = 0;
    tick(); settle();
    while (slow_req && wait_cnt < 20) begin
      wait_cnt++;
      tick(); settle();
    end
    check("tmo_cycles", wait_cnt, 8);
    exp_q.push_back(32'h0);
    check_rd("tmo_rd");
    check("tmo_stall", cpu_stall, 0);
    check("tmo_fault", fault, 1);
    check("tmo_faddr", fault_addr, 32'h8000_0020);
    check("tmo_fcount", fault_count, 2);
    tick(); idle_bus(); settle();
    check("tmo_fault_pulse", fault, 0);

    // unmapped load
    tick(); drive(1'b1, 32'h0000_0040, 32'h0, 4'h0); exp_q.push_back(32'h0); settle();
    check("unm_wea", rgn_wea, 0);
    check("unm_stall", cpu_stall, 0);
    tick(); idle_bus(); settle();
    check_rd("unm_rd");
    check("unm_fault", fault, 1);
    check("unm_faddr", fault_addr, 32'h0000_0040);
    check("unm_fcount", fault_count, 3);

    // slow store to writable io region
    tick(); drive(1'b1, 32'h8000_0008, 32'h0000_BEEF, 4'h3); settle();
    check("sst_stall", cpu_stall, 1);
    check("sst_wea_idle", rgn_wea, 0);
    tick(); slow_ack = 1'b1; settle();
    check("sst_wea", rgn_wea, 16'h3000);
    check("sst_req", slow_req, 1);
    check("sst_wdata", rgn_wdata, 32'h0000_BEEF);
    tick(); slow_ack = 1'b0; idle_bus(); settle();
    check("sst_stall_rel", cpu_stall, 0);
    check("sst_valid", cpu_rdata_valid, 0);
    check("sst_fault", fault, 0);

    // reset while waiting on the slow region
    tick(); drive(1'b1, 32'h8000_0004, 32'h0, 4'h0);
    tick(); tick(); settle();
    check("rw_req", slow_req, 1);
    check("rw_stall", cpu_stall, 1);
    #1;
    rst_n = 1'b0;
    idle_bus();
    #1;
    check("rw_req_drop", slow_req, 0);
    check("rw_stall_drop", cpu_stall, 0);
    check("rw_fcount", fault_count, 0);
    tick(); rst_n = 1'b1; settle();
    slow_ack = 1'b1;
    tick(); slow_ack = 1'b0; settle();
    check("rw_late_ack_valid", cpu_rdata_valid, 0);
    check("rw_late_ack_fault", fault, 0);
    check("rw_late_ack_stall", cpu_stall, 0);
    set_rd(1, 32'h33);
    tick(); drive(1'b1, 32'h2000_0000, 32'h0, 4'h0); exp_q.push_back(32'h33); settle();
    check("rw_ld_stall", cpu_stall, 0);
    tick(); idle_bus(); settle();
    check_rd("rw_ld");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
